// File: rtl/move_sequencer.sv
// Move sequencer: arbitrates appear / gravity / user moves into a move checker and applies verdicts.
// Move codes: 1 LEFT, 2 RIGHT, 3 DOWN, 4 ROTATE, 5 APPEAR. Option: MOVE_SEQ_USER_FIRST_EN.
module move_sequencer #(
  parameter int unsigned EVT_FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       user_evt_valid_i,
  input  logic [2:0] user_evt_i,
  input  logic       tick_i,
  input  logic       appear_i,
  output logic       check_run_o,
  output logic [2:0] check_req_move_o,
  input  logic       check_done_i,
  input  logic       check_can_move_i,
  input  logic [1:0] check_move_x_i,
  input  logic [1:0] check_move_y_i,
  output logic       blk_upd_o,
  output logic [1:0] blk_dx_o,
  output logic [1:0] blk_dy_o,
  output logic       blk_rotate_o,
  output logic       blk_lock_o,
  output logic       game_over_o,
  output logic       evt_drop_o,
  output logic       busy_o
);

  localparam int unsigned PtrW = (EVT_FIFO_DEPTH > 2) ? $clog2(EVT_FIFO_DEPTH) : 1;
  localparam logic [PtrW:0] FullCnt = EVT_FIFO_DEPTH[PtrW:0];

  localparam logic [2:0] MoveLeft   = 3'd1;
  localparam logic [2:0] MoveRight  = 3'd2;
  localparam logic [2:0] MoveDown   = 3'd3;
  localparam logic [2:0] MoveRotate = 3'd4;
  localparam logic [2:0] MoveAppear = 3'd5;

  typedef enum logic [1:0] {StIdle, StRun, StWait} state_e;

  state_e          state_q;
  logic            pend_appear_q, pend_tick_q, game_over_q;
  logic            check_run_q, blk_upd_q, blk_rotate_q, blk_lock_q, evt_drop_q;
  logic [2:0]      req_move_q;
  logic [1:0]      blk_dx_q, blk_dy_q;
  logic [2:0]      fifo_mem_q [EVT_FIFO_DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PtrW:0]   count_q;

  logic       user_ok, fifo_empty, fifo_full, idle;
  logic       sel_appear, sel_tick, sel_fifo;
  logic       done_wait, reject, flush, push, pop, drop;
  logic [2:0] sel_code;

  always_comb begin
    user_ok    = user_evt_valid_i && !game_over_q &&
                 (user_evt_i == MoveLeft || user_evt_i == MoveRight ||
                  user_evt_i == MoveDown || user_evt_i == MoveRotate);
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FullCnt);
    idle       = (state_q == StIdle);
    sel_appear = idle && pend_appear_q;
`ifdef MOVE_SEQ_USER_FIRST_EN
    sel_fifo   = idle && !pend_appear_q && !fifo_empty;
    sel_tick   = idle && !pend_appear_q && fifo_empty && pend_tick_q;
`else
    sel_tick   = idle && !pend_appear_q && pend_tick_q;
    sel_fifo   = idle && !pend_appear_q && !pend_tick_q && !fifo_empty;
`endif
    sel_code = 3'd0;
    if (sel_appear)    sel_code = MoveAppear;
    else if (sel_tick) sel_code = MoveDown;
    else if (sel_fifo) sel_code = fifo_mem_q[rd_ptr_q];
    done_wait = (state_q == StWait) && check_done_i;
    reject    = done_wait && !check_can_move_i;
    // A rejected DOWN or APPEAR discards everything queued behind it, including same-cycle pushes.
    flush = reject && (req_move_q == MoveDown || req_move_q == MoveAppear);
    pop   = sel_fifo;
    push  = user_ok && !flush && (!fifo_full || pop);
    drop  = user_ok && !flush && fifo_full && !pop;
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem_q[wr_ptr_q] <= user_evt_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= StIdle;
      pend_appear_q <= 1'b0;
      pend_tick_q   <= 1'b0;
      game_over_q   <= 1'b0;
      check_run_q   <= 1'b0;
      req_move_q    <= 3'd0;
      blk_upd_q     <= 1'b0;
      blk_dx_q      <= 2'd0;
      blk_dy_q      <= 2'd0;
      blk_rotate_q  <= 1'b0;
      blk_lock_q    <= 1'b0;
      evt_drop_q    <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      check_run_q  <= 1'b0;
      blk_upd_q    <= 1'b0;
      blk_dx_q     <= 2'd0;
      blk_dy_q     <= 2'd0;
      blk_rotate_q <= 1'b0;
      blk_lock_q   <= 1'b0;
      evt_drop_q   <= drop;

      // A new strobe in the cycle its flag is consumed re-arms the flag.
      if (appear_i)        pend_appear_q <= 1'b1;
      else if (sel_appear) pend_appear_q <= 1'b0;

      if (flush)                         pend_tick_q <= 1'b0;
      else if (tick_i && !game_over_q)   pend_tick_q <= 1'b1;
      else if (sel_tick)                 pend_tick_q <= 1'b0;

      if (appear_i)                                  game_over_q <= 1'b0;
      else if (reject && req_move_q == MoveAppear)   game_over_q <= 1'b1;

      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (push && !pop)      count_q <= count_q + 1'b1;
        else if (pop && !push) count_q <= count_q - 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (sel_appear || sel_tick || sel_fifo) begin
            req_move_q  <= sel_code;
            check_run_q <= 1'b1;
            state_q     <= StRun;
          end
        end
        StRun: state_q <= StWait;
        StWait: begin
          if (check_done_i) begin
            state_q <= StIdle;
            if (check_can_move_i) begin
              if (req_move_q != MoveAppear) begin
                blk_upd_q    <= 1'b1;
                blk_dx_q     <= check_move_x_i;
                blk_dy_q     <= check_move_y_i;
                blk_rotate_q <= (req_move_q == MoveRotate);
              end
            end else if (req_move_q == MoveDown) begin
              blk_lock_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign check_run_o      = check_run_q;
  assign check_req_move_o = req_move_q;
  assign blk_upd_o        = blk_upd_q;
  assign blk_dx_o         = blk_dx_q;
  assign blk_dy_o         = blk_dy_q;
  assign blk_rotate_o     = blk_rotate_q;
  assign blk_lock_o       = blk_lock_q;
  assign game_over_o      = game_over_q;
  assign evt_drop_o       = evt_drop_q;
  assign busy_o           = (state_q != StIdle);

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: directed scenarios then random traffic, checked every cycle
// against a queue-based transaction model.
module tb_move_sequencer;
  localparam int unsigned Depth = 4;
  localparam logic [2:0] L = 3'd1, R = 3'd2, D = 3'd3, ROT = 3'd4, AP = 3'd5;

  logic       clk_i = 1'b0, rst_n_i = 1'b0;
  logic       user_evt_valid_i = 1'b0, tick_i = 1'b0, appear_i = 1'b0;
  logic [2:0] user_evt_i = 3'd0;
  logic       check_run_o, check_done_i = 1'b0, check_can_move_i = 1'b0;
  logic [2:0] check_req_move_o;
  logic [1:0] check_move_x_i = 2'd0, check_move_y_i = 2'd0;
  logic       blk_upd_o, blk_rotate_o, blk_lock_o, game_over_o, evt_drop_o, busy_o;
  logic [1:0] blk_dx_o, blk_dy_o;

  move_sequencer #(.EVT_FIFO_DEPTH(Depth)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .user_evt_valid_i(user_evt_valid_i),
    .user_evt_i(user_evt_i), .tick_i(tick_i), .appear_i(appear_i),
    .check_run_o(check_run_o), .check_req_move_o(check_req_move_o),
    .check_done_i(check_done_i), .check_can_move_i(check_can_move_i),
    .check_move_x_i(check_move_x_i), .check_move_y_i(check_move_y_i),
    .blk_upd_o(blk_upd_o), .blk_dx_o(blk_dx_o), .blk_dy_o(blk_dy_o),
    .blk_rotate_o(blk_rotate_o), .blk_lock_o(blk_lock_o), .game_over_o(game_over_o),
    .evt_drop_o(evt_drop_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0, n_err = 0, cyc = 0;
  int obs_runs = 0, obs_upd = 0, obs_lock = 0, obs_drop = 0;
  logic [2:0] run_log[$];
  logic [1:0] last_dx, last_dy;

  // Transaction model: phase 0 idle, 1 checker started, 2 awaiting verdict.
  int         m_phase;
  logic [2:0] m_cur, m_q[$];
  bit         m_pa, m_pt, m_go;
  bit         e_run, e_upd, e_rot, e_lock, e_drop;
  logic [1:0] e_dx, e_dy;

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_cur = 3'd0; m_q.delete(); m_pa = 0; m_pt = 0; m_go = 0;
    {e_run, e_upd, e_rot, e_lock, e_drop, e_dx, e_dy} = '0;
  endtask

  task automatic model_step();
    bit flush, ev_ok, go_set, clr_pa, clr_pt, have;
    logic [2:0] sel;
    {e_run, e_upd, e_rot, e_lock, e_drop, e_dx, e_dy} = '0;
    flush = 0; go_set = 0; clr_pa = 0; clr_pt = 0; have = 0; sel = 3'd0;
    ev_ok = user_evt_valid_i && !m_go && (user_evt_i inside {L, R, D, ROT});
    if (m_phase == 0) begin
      if (m_pa) begin have = 1; sel = AP; clr_pa = 1; end
`ifdef MOVE_SEQ_USER_FIRST_EN
      else if (m_q.size() > 0) begin have = 1; sel = m_q.pop_front(); end
      else if (m_pt) begin have = 1; sel = D; clr_pt = 1; end
`else
      else if (m_pt) begin have = 1; sel = D; clr_pt = 1; end
      else if (m_q.size() > 0) begin have = 1; sel = m_q.pop_front(); end
`endif
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (check_done_i) begin
      m_phase = 0;
      if (check_can_move_i) begin
        if (m_cur != AP) begin
          e_upd = 1; e_dx = check_move_x_i; e_dy = check_move_y_i; e_rot = (m_cur == ROT);
        end
      end else if (m_cur == D) begin
        e_lock = 1; flush = 1;
      end else if (m_cur == AP) begin
        go_set = 1; flush = 1;
      end
    end
    if (have) begin m_cur = sel; m_phase = 1; e_run = 1; end
    if (flush) m_q.delete();
    if (ev_ok && !flush) begin
      if (m_q.size() < Depth) m_q.push_back(user_evt_i);
      else e_drop = 1;
    end
    if (appear_i) m_pa = 1; else if (clr_pa) m_pa = 0;
    if (flush) m_pt = 0; else if (tick_i && !m_go) m_pt = 1; else if (clr_pt) m_pt = 0;
    if (appear_i) m_go = 0; else if (go_set) m_go = 1;
  endtask

  function automatic logic [13:0] obs_vec();
    return {check_run_o, check_req_move_o, blk_upd_o, blk_dx_o, blk_dy_o, blk_rotate_o,
            blk_lock_o, game_over_o, evt_drop_o, busy_o};
  endfunction

  task automatic cycle();
    @(posedge clk_i);
    if (!rst_n_i) model_reset(); else model_step();
    #1;
    cyc++;
    chk($sformatf("outputs_cyc%0d", cyc), 32'(obs_vec()),
        32'({e_run, m_cur, e_upd, e_dx, e_dy, e_rot, e_lock, m_go, e_drop, m_phase != 0}));
    if (check_run_o) begin obs_runs++; run_log.push_back(check_req_move_o); end
    if (blk_upd_o) begin obs_upd++; last_dx = blk_dx_o; last_dy = blk_dy_o; end
    if (blk_lock_o) obs_lock++;
    if (evt_drop_o) obs_drop++;
    user_evt_valid_i = 0; tick_i = 0; appear_i = 0; check_done_i = 0;
    check_can_move_i = 0; check_move_x_i = 0; check_move_y_i = 0;
  endtask

  task automatic user(logic [2:0] code);
    user_evt_valid_i = 1; user_evt_i = code;
  endtask

  task automatic wait_phase(int p, string tag);
    int n = 0;
    while (m_phase != p && n < 40) begin cycle(); n++; end
    chk(tag, 32'(m_phase == p && busy_o === 1'b1), 32'd1);
  endtask

  task automatic respond(bit can, logic [1:0] x, logic [1:0] y);
    wait_phase(2, "wait_reached");
    check_done_i = 1; check_can_move_i = can; check_move_x_i = x; check_move_y_i = y;
    cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int r0, u0, l0, d0, cnt;
    logic [2:0] first, second;
    logic [2:0] seq[6];
    model_reset();
    cycle(); cycle();
    chk("reset_state", 32'(obs_vec()), 32'd0);
    rst_n_i = 1;
    cycle();

    // Single LEFT accepted after a slow checker.
    r0 = obs_runs; u0 = obs_upd;
    user(L); cycle();
    wait_phase(2, "left_wait");
    repeat (17) cycle();
    respond(1, 2'b11, 2'b00);
    chk("left_runs", obs_runs - r0, 1);
    chk("left_upd", obs_upd - u0, 1);
    chk("left_dxdy", {last_dx, last_dy}, 4'b1100);

    // Tick and user move in the same idle cycle.
    run_log.delete();
    tick_i = 1; user(R); cycle();
    respond(1, 2'b00, 2'b01);
    respond(1, 2'b01, 2'b00);
`ifdef MOVE_SEQ_USER_FIRST_EN
    first = R; second = D;
`else
    first = D; second = R;
`endif
    chk("prio_first", 32'(run_log[0]), 32'(first));
    chk("prio_second", 32'(run_log[1]), 32'(second));

    // Six events during one wait: two drops, four queued in order.
    run_log.delete(); d0 = obs_drop;
    seq = '{R, ROT, L, D, R, L};
    user(L); cycle();
    wait_phase(2, "burst_wait");
    for (int i = 0; i < 6; i++) begin user(seq[i]); cycle(); end
    chk("burst_drops", obs_drop - d0, 2);
    for (int i = 0; i < 5; i++) respond(1, 2'b01, 2'b00);
    repeat (3) cycle();
    chk("burst_runs", run_log.size(), 5);
    for (int i = 0; i < 4; i++) chk($sformatf("burst_order%0d", i), 32'(run_log[i + 1]), 32'(seq[i]));

    // Rejected DOWN flushes queued moves.
    r0 = obs_runs; l0 = obs_lock;
    tick_i = 1; cycle();
    wait_phase(2, "lock_wait");
    user(L); cycle(); user(R); cycle(); user(ROT); cycle();
    respond(0, 2'b00, 2'b01);
    repeat (10) cycle();
    chk("lock_pulse", obs_lock - l0, 1);
    chk("lock_runs", obs_runs - r0, 1);

    // Rejected APPEAR: game over ignores traffic until the next appear.
    appear_i = 1; cycle();
    respond(0, 2'b00, 2'b00);
    r0 = obs_runs; u0 = obs_upd;
    for (int i = 0; i < 5; i++) begin tick_i = 1; user(D); cycle(); end
    chk("go_flag", 32'(game_over_o), 32'd1);
    chk("go_no_runs", obs_runs - r0, 0);
    appear_i = 1; cycle();
    chk("go_cleared", 32'(game_over_o), 32'd0);
    cycle();
    chk("go_restart", 32'({check_run_o, check_req_move_o}), 32'({1'b1, AP}));
    respond(1, 2'b00, 2'b00);
    chk("appear_no_upd", obs_upd - u0, 0);

    // Reset during wait, then a stale done.
    u0 = obs_upd;
    user(L); cycle();
    wait_phase(2, "rst_wait");
    #2 rst_n_i = 0;
    #1 chk("async_reset", 32'(obs_vec()), 32'd0);
    model_reset();
    cycle(); cycle();
    rst_n_i = 1;
    check_done_i = 1; check_can_move_i = 1; check_move_x_i = 2'b01;
    cycle();
    repeat (3) cycle();
    chk("stale_done_upd", obs_upd - u0, 0);

    // Random traffic.
    cnt = 0;
    for (int i = 0; i < 1500; i++) begin
      user_evt_valid_i = ($urandom % 4) == 0;
      user_evt_i = 3'($urandom_range(0, 7));
      tick_i = ($urandom % 8) == 0;
      appear_i = ($urandom % 40) == 0;
      if (m_phase == 2) begin
        if (cnt == 0) begin
          check_done_i = 1; check_can_move_i = ($urandom % 4) != 0;
          check_move_x_i = 2'($urandom); check_move_y_i = 2'($urandom);
        end else cnt--;
      end else if (($urandom % 20) == 0) begin
        check_done_i = 1; check_can_move_i = 1'($urandom); check_move_x_i = 2'($urandom);
      end
      cycle();
      if (m_phase == 1) cnt = $urandom_range(0, 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
